booth_mul_seq: RTL

- Iterative radix-4 Booth multiplier for the Mini-SRC datapath, replacing the single-cycle combinational multiplier for the MUL/MULU instructions.
- Width is parameterised; signed and unsigned modes are supported; start/busy/done handshake to the control unit.
- Retires one Booth group (2 multiplier bits) per clock and writes the 2*WIDTH-bit product to HI/LO.

---
 rtl/booth_mul_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-4 Booth multiplier for MUL/MULU.
// Retires one Booth group (two multiplier bits) per clock and writes the
// 2*WIDTH-bit product to HI/LO, with a start/busy/done handshake.
// Optional build macro: BOOTH_MUL_EARLY_TERM_EN. When it is defined, the
// operation finishes as soon as the remaining multiplier bits are all-0 or
// all-1, because those groups would only add zero.
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int NGRP = WIDTH / 2 + 1;
  localparam int GW   = $clog2(NGRP + 1);
  localparam int XW   = WIDTH + 2;
  localparam int AW   = 2 * WIDTH + 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   a_x, b_x;
  logic [AW-1:0]   acc, acc_next;
  logic [GW-1:0]   grp;
  logic [GW:0]     shamt;
  logic [XW:0]     b_ext;
  logic [2:0]      grp_bits;
  logic [XW+1:0]   a4, pp;
  logic [AW-1:0]   pp_ext;
  logic            last_grp, finish;
`ifdef BOOTH_MUL_EARLY_TERM_EN
  logic signed [XW-1:0] b_sh, b_rem;
`endif

  // Booth recoding of the current group and the next accumulator value.
  always_comb begin
    // NOTE: every variable gets a default up front so no path can infer a latch.
    pp       = '0;
    shamt    = {grp, 1'b0};
    b_ext    = {b_x, 1'b0};
    grp_bits = 3'(b_ext >> shamt);
    a4       = {{2{a_x[XW-1]}}, a_x};
    case (grp_bits)
      3'b001, 3'b010: pp = a4;
      3'b011:         pp = a4 << 1;
      3'b100:         pp = -(a4 << 1);
      3'b101, 3'b110: pp = -a4;
      default:        pp = '0;
    endcase
    pp_ext   = {{WIDTH{pp[XW+1]}}, pp};
    acc_next = acc + (pp_ext << shamt);
    last_grp = (grp == GW'(NGRP - 1));
`ifdef BOOTH_MUL_EARLY_TERM_EN
    // Bits from 2i+1 upward; identical bits mean all later groups recode to 0.
    b_sh   = $signed(b_x) >>> shamt;
    b_rem  = b_sh >>> 1;
    finish = last_grp || (b_rem == '0) || (&b_rem);
`else
    finish = last_grp;
`endif
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state always uses non-blocking assignments.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (finish) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, accumulation and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_x <= '0;
      b_x <= '0;
      acc <= '0;
      grp <= '0;
      HI  <= '0;
      LO  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_x <= is_signed ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
            b_x <= is_signed ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};
            acc <= '0;
            grp <= '0;
          end
        end
        RUN: begin
          acc <= acc_next;
          grp <= grp + 1'b1;
          if (finish) begin
            HI <= acc_next[2*WIDTH-1:WIDTH];
            LO <= acc_next[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
